// File: rtl/uart_time_msg_sender.sv
// Sequencer feeding txCore: snapshots BCD time on request and streams "HH:MM:SS<EOL>" byte by byte.
// Define TIME_MSG_DATE_EN to add date inputs and prefix the line with "YY-MM-DD ".
module uart_time_msg_sender #(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter bit         EOL_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
`ifdef TIME_MSG_DATE_EN
  input  logic [7:0] year_bcd,
  input  logic [7:0] mon_bcd,
  input  logic [7:0] date_bcd,
`endif
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       msg_busy,
  output logic       msg_done,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, NEXT, FINISH} state_e;

`ifdef TIME_MSG_DATE_EN
  localparam logic [4:0] IDX_BASE = 5'd9;
`else
  localparam logic [4:0] IDX_BASE = 5'd0;
`endif
  localparam logic [4:0] LAST_IDX = IDX_BASE + (EOL_CRLF ? 5'd9 : 5'd8);

  state_e      state, nextState;
  logic        pending;
  logic [7:0]  dropCnt;
  logic [4:0]  charIdx;
  logic [7:0]  hourSnap, minSnap, secSnap;
  logic [7:0]  curChar;
`ifdef TIME_MSG_DATE_EN
  logic [7:0]  yearSnap, monSnap, dateSnap;
`endif

  function automatic logic [7:0] bcdDigit(input logic [3:0] nib);
    return (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      dropCnt  <= '0;
      charIdx  <= '0;
      hourSnap <= '0;
      minSnap  <= '0;
      secSnap  <= '0;
`ifdef TIME_MSG_DATE_EN
      yearSnap <= '0;
      monSnap  <= '0;
      dateSnap <= '0;
`endif
    end else begin
      state <= nextState;
      // Entering LOAD consumes one request; a send arriving alongside re-queues it.
      if (nextState == LOAD) begin
        pending <= (state == FINISH) ? send : (pending & send);
      end else if (send && state != IDLE) begin
        if (!pending)
          pending <= 1'b1;
        else if (dropCnt != 8'hFF)
          dropCnt <= dropCnt + 8'd1;
      end
      if (state == LOAD) begin
        hourSnap <= hour_bcd;
        minSnap  <= min_bcd;
        secSnap  <= sec_bcd;
`ifdef TIME_MSG_DATE_EN
        yearSnap <= year_bcd;
        monSnap  <= mon_bcd;
        dateSnap <= date_bcd;
`endif
        charIdx  <= '0;
      end else if (state == NEXT && charIdx != LAST_IDX) begin
        charIdx <= charIdx + 5'd1;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (send || pending) nextState = LOAD;
      LOAD:    nextState = ISSUE;
      ISSUE:   if (!tx_busy) nextState = WAIT;
      WAIT:    if (tx_done) nextState = NEXT;
      NEXT:    nextState = (charIdx == LAST_IDX) ? FINISH : ISSUE;
      FINISH:  nextState = pending ? LOAD : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    curChar = 8'h0A;
    case (charIdx)
`ifdef TIME_MSG_DATE_EN
      5'd0:            curChar = bcdDigit(yearSnap[7:4]);
      5'd1:            curChar = bcdDigit(yearSnap[3:0]);
      5'd2:            curChar = 8'h2D;
      5'd3:            curChar = bcdDigit(monSnap[7:4]);
      5'd4:            curChar = bcdDigit(monSnap[3:0]);
      5'd5:            curChar = 8'h2D;
      5'd6:            curChar = bcdDigit(dateSnap[7:4]);
      5'd7:            curChar = bcdDigit(dateSnap[3:0]);
      5'd8:            curChar = 8'h20;
`endif
      IDX_BASE:        curChar = bcdDigit(hourSnap[7:4]);
      IDX_BASE + 5'd1: curChar = bcdDigit(hourSnap[3:0]);
      IDX_BASE + 5'd2: curChar = SEP_CHAR;
      IDX_BASE + 5'd3: curChar = bcdDigit(minSnap[7:4]);
      IDX_BASE + 5'd4: curChar = bcdDigit(minSnap[3:0]);
      IDX_BASE + 5'd5: curChar = SEP_CHAR;
      IDX_BASE + 5'd6: curChar = bcdDigit(secSnap[7:4]);
      IDX_BASE + 5'd7: curChar = bcdDigit(secSnap[3:0]);
      IDX_BASE + 5'd8: curChar = EOL_CRLF ? 8'h0D : 8'h0A;
      default:         curChar = 8'h0A;
    endcase
  end

  always_comb begin
    tx_en    = (state == ISSUE) && !tx_busy;
    tx_data  = tx_en ? curChar : '0;
    msg_busy = (state == LOAD) || (state == ISSUE) || (state == WAIT) || (state == NEXT);
    msg_done = (state == FINISH);
    drop_cnt = dropCnt;
  end

endmodule

// File: tb/tb_uart_time_msg_sender.sv
// Bench for uart_time_msg_sender: CRLF instance (A) and LF instance (B), each with a txCore model.
module tb_uart_time_msg_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] hourBcd = 8'h12, minBcd = 8'h34, secBcd = 8'h56;
`ifdef TIME_MSG_DATE_EN
  logic [7:0] yearBcd = 8'h00, monBcd = 8'h01, dateBcd = 8'h01;
`endif

  logic       txEnA, msgBusyA, msgDoneA, txEnB, msgBusyB, msgDoneB;
  logic [7:0] txDataA, dropCntA, txDataB, dropCntB;
  logic       txBusyA = 1'b0, txDoneA = 1'b0, txBusyB = 1'b0, txDoneB = 1'b0;
  int         cntA = 0, cntB = 0;
  int         frameLen = 4;

  int         checkCnt = 0, passCnt = 0, violCnt = 0;
  int         doneA = 0, doneB = 0;
  logic [7:0] qA[$], qB[$];
  logic       txEnPrevA = 1'b0, txEnPrevB = 1'b0;

  uart_time_msg_sender dutA (
    .clk(clk), .rst(rst), .send(send),
    .hour_bcd(hourBcd), .min_bcd(minBcd), .sec_bcd(secBcd),
`ifdef TIME_MSG_DATE_EN
    .year_bcd(yearBcd), .mon_bcd(monBcd), .date_bcd(dateBcd),
`endif
    .tx_en(txEnA), .tx_data(txDataA), .tx_busy(txBusyA), .tx_done(txDoneA),
    .msg_busy(msgBusyA), .msg_done(msgDoneA), .drop_cnt(dropCntA)
  );

  uart_time_msg_sender #(.SEP_CHAR(8'h3A), .EOL_CRLF(1'b0)) dutB (
    .clk(clk), .rst(rst), .send(send),
    .hour_bcd(hourBcd), .min_bcd(minBcd), .sec_bcd(secBcd),
`ifdef TIME_MSG_DATE_EN
    .year_bcd(yearBcd), .mon_bcd(monBcd), .date_bcd(dateBcd),
`endif
    .tx_en(txEnB), .tx_data(txDataB), .tx_busy(txBusyB), .tx_done(txDoneB),
    .msg_busy(msgBusyB), .msg_done(msgDoneB), .drop_cnt(dropCntB)
  );

  // txCore models: busy one cycle after en, done pulse frameLen cycles later.
  always @(posedge clk) begin
    txDoneA <= 1'b0;
    if (rst) begin
      txBusyA <= 1'b0; cntA <= 0;
    end else if (txEnA) begin
      txBusyA <= 1'b1; cntA <= frameLen;
    end else if (txBusyA) begin
      if (cntA <= 1) begin txBusyA <= 1'b0; txDoneA <= 1'b1; end
      cntA <= cntA - 1;
    end
  end

  always @(posedge clk) begin
    txDoneB <= 1'b0;
    if (rst) begin
      txBusyB <= 1'b0; cntB <= 0;
    end else if (txEnB) begin
      txBusyB <= 1'b1; cntB <= frameLen;
    end else if (txBusyB) begin
      if (cntB <= 1) begin txBusyB <= 1'b0; txDoneB <= 1'b1; end
      cntB <= cntB - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (txEnA) qA.push_back(txDataA);
      if (txEnB) qB.push_back(txDataB);
      if (msgDoneA) doneA++;
      if (msgDoneB) doneB++;
      if (txEnA && (txBusyA || txEnPrevA)) violCnt++;
      if (txEnB && (txBusyB || txEnPrevB)) violCnt++;
    end
    txEnPrevA = txEnA;
    txEnPrevB = txEnB;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic sendPulse();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic clearCaps();
    qA.delete(); qB.delete();
    doneA = 0; doneB = 0;
  endtask

  task automatic waitLinesA(input int n);
    int k = 0;
    while (doneA < n && k < 5000) begin tick(); k++; end
    checkCnt++;
    if (doneA < n) $display("FAIL wait_lines: got %0d lines, want %0d", doneA, n);
    else passCnt++;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; send = 1'b0;
    repeat (3) tick();
    checkCnt++;
    if ({txEnA, txDataA, msgBusyA, msgDoneA, dropCntA} !== 19'h0)
      $display("FAIL reset_outputs: got en=%b data=%h busy=%b done=%b drop=%h, want all 0",
               txEnA, txDataA, msgBusyA, msgDoneA, dropCntA);
    else passCnt++;
    rst = 1'b0;
    repeat (2) tick();
    checkCnt++;
    if (msgBusyA !== 1'b0 || txEnA !== 1'b0) $display("FAIL idle_after_reset: busy=%b en=%b, want 0 0", msgBusyA, txEnA);
    else passCnt++;
  endtask

  task automatic test_single_line();
    logic [7:0] exp[10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
    clearCaps();
    hourBcd = 8'h12; minBcd = 8'h34; secBcd = 8'h56;
    sendPulse();
    checkCnt++;
    if (msgBusyA !== 1'b1 || txEnA !== 1'b0) $display("FAIL load_cycle: busy=%b en=%b, want 1 0", msgBusyA, txEnA);
    else passCnt++;
    tick();
    checkCnt++;
    if ({txEnA, txDataA} !== 9'h131) $display("FAIL first_byte_latency: en=%b data=%h, want 1 31", txEnA, txDataA);
    else passCnt++;
    waitLinesA(1);
    checkCnt++;
    if (qA.size() != 10) $display("FAIL line_len_crlf: got %0d, want 10", qA.size());
    else passCnt++;
    for (int i = 0; i < 10; i++) begin
      checkCnt++;
      if (i >= qA.size() || qA[i] !== exp[i]) $display("FAIL line_byte_%0d: got %h, want %h", i, (i < qA.size()) ? qA[i] : 8'hxx, exp[i]);
      else passCnt++;
    end
    checkCnt++;
    if (doneA != 1 || dropCntA !== 8'h00) $display("FAIL single_done_drop: done=%0d drop=%h, want 1 00", doneA, dropCntA);
    else passCnt++;
  endtask

  task automatic test_snapshot();
    logic [7:0] exp[4] = '{8'h35, 8'h36, 8'h0D, 8'h0A};
    clearCaps();
    secBcd = 8'h56;
    sendPulse();
    tick();
    secBcd = 8'h57;
    waitLinesA(1);
    for (int i = 0; i < 4; i++) begin
      checkCnt++;
      if (qA.size() != 10 || qA[6 + i] !== exp[i]) $display("FAIL snapshot_byte_%0d: got %h, want %h", 6 + i, (qA.size() > 6 + i) ? qA[6 + i] : 8'hxx, exp[i]);
      else passCnt++;
    end
    secBcd = 8'h56;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp2[2] = '{8'h35, 8'h37};
    int k = 0;
    clearCaps();
    secBcd = 8'h56;
    sendPulse();
    repeat (5) tick();
    sendPulse();
    secBcd = 8'h57;
    repeat (5) tick();
    sendPulse();
    while (doneA < 1 && k < 5000) begin tick(); k++; end
    tick();
    checkCnt++;
    if (msgBusyA !== 1'b1) $display("FAIL busy_second_load: got %b, want 1", msgBusyA);
    else passCnt++;
    waitLinesA(2);
    checkCnt++;
    if (qA.size() != 20 || doneA != 2) $display("FAIL two_lines: got %0d bytes %0d lines, want 20 2", qA.size(), doneA);
    else passCnt++;
    checkCnt++;
    if (dropCntA !== 8'h01) $display("FAIL drop_one: got %h, want 01", dropCntA);
    else passCnt++;
    checkCnt++;
    if (qA.size() != 20 || qA[7] !== 8'h36) $display("FAIL first_line_sec: got %h, want 36", (qA.size() > 7) ? qA[7] : 8'hxx);
    else passCnt++;
    for (int i = 0; i < 2; i++) begin
      checkCnt++;
      if (qA.size() != 20 || qA[16 + i] !== exp2[i]) $display("FAIL resnapshot_byte_%0d: got %h, want %h", 16 + i, (qA.size() > 16 + i) ? qA[16 + i] : 8'hxx, exp2[i]);
      else passCnt++;
    end
    secBcd = 8'h56;
  endtask

  task automatic test_bad_digit_lf();
    logic [7:0] expA[4] = '{8'h35, 8'h3F, 8'h0D, 8'h0A};
    logic [7:0] expB[9] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h3F, 8'h0A};
    clearCaps();
    secBcd = 8'h5A;
    sendPulse();
    waitLinesA(1);
    for (int i = 0; i < 4; i++) begin
      checkCnt++;
      if (qA.size() != 10 || qA[6 + i] !== expA[i]) $display("FAIL bad_digit_byte_%0d: got %h, want %h", 6 + i, (qA.size() > 6 + i) ? qA[6 + i] : 8'hxx, expA[i]);
      else passCnt++;
    end
    checkCnt++;
    if (qB.size() != 9 || doneB != 1) $display("FAIL line_len_lf: got %0d bytes %0d lines, want 9 1", qB.size(), doneB);
    else passCnt++;
    for (int i = 0; i < 9; i++) begin
      checkCnt++;
      if (i >= qB.size() || qB[i] !== expB[i]) $display("FAIL lf_byte_%0d: got %h, want %h", i, (i < qB.size()) ? qB[i] : 8'hxx, expB[i]);
      else passCnt++;
    end
    secBcd = 8'h56;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clearCaps();
    sendPulse();
    while (qA.size() < 4 && k < 2000) begin tick(); k++; end
    tick();
    rst = 1'b1;
    tick();
    checkCnt++;
    if ({txEnA, txDataA, msgBusyA, msgDoneA, dropCntA} !== 19'h0)
      $display("FAIL reset_mid_outputs: got en=%b data=%h busy=%b done=%b drop=%h, want all 0",
               txEnA, txDataA, msgBusyA, msgDoneA, dropCntA);
    else passCnt++;
    rst = 1'b0;
    repeat (60) tick();
    checkCnt++;
    if (qA.size() != 4 || doneA != 0) $display("FAIL no_en_after_reset: got %0d bytes %0d lines, want 4 0", qA.size(), doneA);
    else passCnt++;
  endtask

  task automatic test_drop_saturate();
    frameLen = 200;
    clearCaps();
    sendPulse();
    tick();
    sendPulse();
    for (int i = 0; i < 254; i++) begin tick(); sendPulse(); end
    checkCnt++;
    if (dropCntA !== 8'hFE) $display("FAIL drop_254: got %h, want fe", dropCntA);
    else passCnt++;
    tick(); sendPulse();
    checkCnt++;
    if (dropCntA !== 8'hFF) $display("FAIL drop_255: got %h, want ff", dropCntA);
    else passCnt++;
    for (int i = 0; i < 5; i++) begin tick(); sendPulse(); end
    checkCnt++;
    if (dropCntA !== 8'hFF || dropCntB !== 8'hFF) $display("FAIL drop_saturate: got A=%h B=%h, want ff ff", dropCntA, dropCntB);
    else passCnt++;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    frameLen = 4;
    tick();
  endtask

`ifdef TIME_MSG_DATE_EN
  task automatic test_date();
    logic [7:0] exp[19] = '{8'h32, 8'h34, 8'h2D, 8'h30, 8'h37, 8'h2D, 8'h31, 8'h35, 8'h20, 8'h30,
                            8'h31, 8'h3A, 8'h30, 8'h32, 8'h3A, 8'h30, 8'h33, 8'h0D, 8'h0A};
    clearCaps();
    yearBcd = 8'h24; monBcd = 8'h07; dateBcd = 8'h15;
    hourBcd = 8'h01; minBcd = 8'h02; secBcd = 8'h03;
    sendPulse();
    waitLinesA(1);
    checkCnt++;
    if (qA.size() != 19 || qB.size() != 18) $display("FAIL date_line_len: got A=%0d B=%0d, want 19 18", qA.size(), qB.size());
    else passCnt++;
    for (int i = 0; i < 19; i++) begin
      checkCnt++;
      if (i >= qA.size() || qA[i] !== exp[i]) $display("FAIL date_byte_%0d: got %h, want %h", i, (i < qA.size()) ? qA[i] : 8'hxx, exp[i]);
      else passCnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_line();
    test_snapshot();
    test_back_to_back();
    test_bad_digit_lf();
    test_reset_mid();
    test_drop_saturate();
`ifdef TIME_MSG_DATE_EN
    test_date();
`endif
    checkCnt++;
    if (violCnt != 0) $display("FAIL handshake: got %0d tx_en violations, want 0", violCnt);
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
